lab5_mac_accel: RTL and testbench

Avalon-MM slave multiply-accumulate accelerator in the lab5 FPGA fabric, mapped behind the HPS lightweight HPS-to-FPGA bridge in the lab5 system. Software pushes signed 16-bit operand pairs into an internal FIFO. It then issues a start command. A pipelined engine drains the FIFO, accumulates the sum of X·Y into a 48-bit signed accumulator, and reports done through a status register.

---
 rtl/lab5_mac_pkg.sv | 46 ++++
 rtl/lab5_mac_accel_fifo.sv | 60 ++++++
 rtl/lab5_mac_accel.sv | 178 +++++++++++++++++
 tb/tb_lab5_mac_accel.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab5_mac_pkg.sv
// Shared constants, register map and types for the lab5 MAC accelerator.
package lab5_mac_pkg;

   localparam int unsigned DATA_W       = 16;
   localparam int unsigned ACC_W        = 48;
   localparam int unsigned FIFO_DEPTH   = 16;
   localparam int unsigned PAIR_W       = 2 * DATA_W;
   localparam int unsigned PROD_W       = 2 * DATA_W;
   localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
   localparam int unsigned LEVEL_W      = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CNT_W        = 16;
   localparam int unsigned BUS_W        = 32;
   localparam int unsigned ADDR_W       = 3;
   localparam int unsigned DRAIN_CYCLES = 2;
   localparam int unsigned DRAIN_W      = 1;

   localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_XIN    = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_YIN    = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_RES_LO = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_RES_HI = 3'd5;
   localparam logic [ADDR_W-1:0] ADDR_COUNT  = 3'd6;

   localparam int unsigned CTRL_START  = 0;
   localparam int unsigned CTRL_CLEAR  = 1;
   localparam int unsigned CTRL_IRQ_EN = 2;

   localparam int unsigned STAT_BUSY     = 0;
   localparam int unsigned STAT_DONE     = 1;
   localparam int unsigned STAT_OVF      = 2;
   localparam int unsigned STAT_LEVEL_LO = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] x;
      logic [DATA_W-1:0] y;
   } pair_t;

endpackage

// File: rtl/lab5_mac_accel_fifo.sv
// Show-ahead operand-pair FIFO; a push on a full FIFO is accepted only alongside a pop.
module lab5_pair_fifo
   import lab5_mac_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               push,
   input  logic [PAIR_W-1:0]  wdata,
   input  logic               pop,
   output logic [PAIR_W-1:0]  rdata,
   output logic               full,
   output logic               empty,
   output logic [LEVEL_W-1:0] level
);

   logic [PAIR_W-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [LEVEL_W-1:0] count;
   logic [LEVEL_W-1:0] count_nxt;
   logic               do_push;
   logic               do_pop;

   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || do_pop);
   assign rdata   = mem[rd_ptr];
   assign level   = count;

   always_comb begin
      count_nxt = count;
      case ({do_push, do_pop})
         2'b10:   count_nxt = count + LEVEL_W'(1);
         2'b01:   count_nxt = count - LEVEL_W'(1);
         default: count_nxt = count;
      endcase
   end

   // Storage is not reset; only pointers and occupancy are.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_nxt;
         empty <= (count_nxt == '0);
         full  <= (count_nxt == LEVEL_W'(FIFO_DEPTH));
      end
   end

endmodule

// File: rtl/lab5_mac_accel.sv
// Avalon-MM MAC accelerator: operand FIFO, run/drain/done sequencer and a
// three-stage multiply-accumulate pipeline into a 48-bit accumulator.
module lab5_mac_accel
   import lab5_mac_pkg::*;
(
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_write,
   input  logic [BUS_W-1:0]  avs_writedata,
   input  logic              avs_read,
   output logic [BUS_W-1:0]  avs_readdata,
   output logic              irq
);

   state_e              state;
   logic [DRAIN_W-1:0]  drain_cnt;
   logic                done;
   logic                done_nxt;
   logic                irq_en;
   logic                irq_en_nxt;
   logic                overflow;
   logic [DATA_W-1:0]   x_latch;
   logic [BUS_W-1:0]    shadow;
   logic [BUS_W-1:0]    status_word;

   logic                wr_ctrl;
   logic                wr_x;
   logic                wr_y;
   logic                clear_req;
   logic                start_go;
   logic                busy;
   logic                pop;
   logic                push_drop;

   logic [PAIR_W-1:0]   fifo_rdata;
   pair_t               head;
   logic                fifo_full;
   logic                fifo_empty;
   logic [LEVEL_W-1:0]  fifo_level;

   logic                op_vld;
   logic signed [DATA_W-1:0] op_x;
   logic signed [DATA_W-1:0] op_y;
   logic                prod_vld;
   logic signed [PROD_W-1:0] prod;
   logic [ACC_W-1:0]    prod_ext;
   logic [ACC_W-1:0]    acc;
   logic [CNT_W-1:0]    mac_count;

   logic                unused_wdata;
   assign unused_wdata = ^avs_writedata[BUS_W-1:DATA_W];

   assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
   assign wr_x      = avs_write && (avs_address == ADDR_XIN);
   assign wr_y      = avs_write && (avs_address == ADDR_YIN);
   assign clear_req = wr_ctrl && avs_writedata[CTRL_CLEAR];
   assign busy      = (state != ST_IDLE);
   assign start_go  = wr_ctrl && avs_writedata[CTRL_START] && !avs_writedata[CTRL_CLEAR] && !busy;
   assign pop       = (state == ST_RUN) && !fifo_empty;
   assign push_drop = wr_y && fifo_full && !pop;
   assign head      = pair_t'(fifo_rdata);
   assign prod_ext  = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

   lab5_pair_fifo u_fifo (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .flush (clear_req),
      .push  (wr_y),
      .wdata ({x_latch, avs_writedata[DATA_W-1:0]}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Next values of done/irq_en so irq can be registered without extra lag.
   always_comb begin
      done_nxt   = done;
      irq_en_nxt = irq_en;
      if (clear_req || start_go) done_nxt = 1'b0;
      else if (state == ST_DONE) done_nxt = 1'b1;
      if (wr_ctrl) irq_en_nxt = avs_writedata[CTRL_IRQ_EN];
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
         done      <= 1'b0;
         irq_en    <= 1'b0;
         irq       <= 1'b0;
         overflow  <= 1'b0;
         x_latch   <= '0;
      end else begin
         done   <= done_nxt;
         irq_en <= irq_en_nxt;
         irq    <= done_nxt && irq_en_nxt;
         if (wr_x) x_latch <= avs_writedata[DATA_W-1:0];
         if (clear_req) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            overflow  <= 1'b0;
         end else begin
            if (push_drop) overflow <= 1'b1;
            case (state)
               ST_IDLE:  if (start_go) state <= ST_RUN;
               ST_RUN:   if (fifo_empty) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                         end
               ST_DRAIN: if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) state <= ST_DONE;
                         else drain_cnt <= drain_cnt + DRAIN_W'(1);
               ST_DONE:  state <= ST_IDLE;
               default:  state <= ST_IDLE;
            endcase
         end
      end
   end

   // Pop -> operand register -> product register -> accumulate.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n || clear_req) begin
         op_vld    <= 1'b0;
         op_x      <= '0;
         op_y      <= '0;
         prod_vld  <= 1'b0;
         prod      <= '0;
         acc       <= '0;
         mac_count <= '0;
      end else begin
         op_vld <= pop;
         if (pop) begin
            op_x <= head.x;
            op_y <= head.y;
         end
         prod_vld <= op_vld;
         if (op_vld) prod <= PROD_W'(op_x) * PROD_W'(op_y);
         if (prod_vld) begin
            acc       <= acc + prod_ext;
            mac_count <= mac_count + CNT_W'(1);
         end
      end
   end

   always_comb begin
      status_word                              = '0;
      status_word[STAT_BUSY]                   = busy;
      status_word[STAT_DONE]                   = done;
      status_word[STAT_OVF]                    = overflow;
      status_word[STAT_LEVEL_LO +: LEVEL_W]    = fifo_level;
   end

   // Read port; a RES_LO read snapshots the upper accumulator bits for RES_HI.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         avs_readdata <= '0;
         shadow       <= '0;
      end else begin
         avs_readdata <= '0;
         if (clear_req) shadow <= '0;
         if (avs_read) begin
            case (avs_address)
               ADDR_STATUS: avs_readdata <= status_word;
               ADDR_RES_LO: begin
                  avs_readdata <= acc[BUS_W-1:0];
                  shadow       <= {{(2*BUS_W - ACC_W){acc[ACC_W-1]}}, acc[ACC_W-1:BUS_W]};
               end
               ADDR_RES_HI: avs_readdata <= shadow;
               ADDR_COUNT:  avs_readdata <= {{(BUS_W - CNT_W){1'b0}}, mac_count};
               default:     avs_readdata <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lab5_mac_accel.sv
// Directed bench for lab5_mac_accel against a transaction-level model of the register file.
module tb_lab5_mac_accel;

   logic        clk_clk       = 1'b0;
   logic        reset_reset_n = 1'b0;
   logic [2:0]  avs_address   = 3'd0;
   logic        avs_write     = 1'b0;
   logic [31:0] avs_writedata = 32'd0;
   logic        avs_read      = 1'b0;
   logic [31:0] avs_readdata;
   logic        irq;

   lab5_mac_accel dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .avs_address   (avs_address),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_read      (avs_read),
      .avs_readdata  (avs_readdata),
      .irq           (irq)
   );

   always #5 clk_clk = ~clk_clk;

   int cyc = 0;
   always @(posedge clk_clk) cyc <= cyc + 1;

   int nvec = 0;
   int nerr = 0;
   bit mon_en = 1'b0;

   localparam int NEVER = 32'h7fff_ffff;

   // Model: queued pairs, results, and the cycle windows of busy and done.
   logic [31:0] mq[$];
   logic [47:0] m_acc;
   logic [31:0] m_shadow;
   logic [15:0] m_cnt;
   logic [15:0] m_x;
   logic        m_ovf;
   logic        m_irq_en;
   int          m_busy_lo, m_busy_hi, m_done_from;

   function automatic bit m_busy(input int c);
      return (c >= m_busy_lo) && (c <= m_busy_hi);
   endfunction

   function automatic bit m_done(input int c);
      return c >= m_done_from;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_acc = '0; m_shadow = '0; m_cnt = '0; m_x = '0;
      m_ovf = 1'b0; m_irq_en = 1'b0;
      m_busy_lo = 1; m_busy_hi = 0; m_done_from = NEVER;
   endtask

   task automatic model_write(input logic [2:0] a, input logic [31:0] d, input int t);
      case (a)
         3'd0: begin
            m_irq_en = d[2];
            if (d[1]) begin
               m_acc = '0; m_cnt = '0; m_shadow = '0; m_ovf = 1'b0;
               mq.delete();
               if (m_busy_hi > t) m_busy_hi = t;
               m_done_from = NEVER;
            end else if (d[0] && !m_busy(t)) begin
               m_busy_lo   = t + 1;
               m_busy_hi   = t + mq.size() + 4;
               m_done_from = t + mq.size() + 5;
               foreach (mq[i]) begin
                  longint p;
                  p = longint'($signed(mq[i][31:16])) * longint'($signed(mq[i][15:0]));
                  m_acc = m_acc + 48'(p);
                  m_cnt = m_cnt + 16'd1;
               end
               mq.delete();
            end
         end
         3'd2: m_x = d[15:0];
         3'd3: if (mq.size() < 16) mq.push_back({m_x, d[15:0]});
               else m_ovf = 1'b1;
         default: ;
      endcase
   endtask

   task automatic model_read(input logic [2:0] a, input int r, output logic [31:0] e);
      e = 32'd0;
      case (a)
         3'd1: begin
            e[0]    = m_busy(r);
            e[1]    = m_done(r);
            e[2]    = m_ovf;
            e[12:8] = 5'(mq.size());
         end
         3'd4: begin
            e        = m_acc[31:0];
            m_shadow = 32'($signed(m_acc[47:32]));
         end
         3'd5: e = m_shadow;
         3'd6: e = {16'd0, m_cnt};
         default: e = 32'd0;
      endcase
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle check of the interrupt line against the model.
   always @(negedge clk_clk) begin
      if (mon_en) check("irq_mon", {31'd0, irq}, {31'd0, m_done(cyc) && m_irq_en});
   end

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      int t;
      t = cyc;
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      @(posedge clk_clk);
      model_write(a, d, t);
      @(negedge clk_clk);
      avs_write = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, input string name, input bit use_lit, input logic [31:0] lit);
      logic [31:0] e;
      model_read(a, cyc, e);
      avs_address = a; avs_read = 1'b1;
      @(posedge clk_clk);
      @(negedge clk_clk);
      avs_read = 1'b0;
      check(name, avs_readdata, e);
      if (use_lit) check({name, "_lit"}, avs_readdata, lit);
   endtask

   task automatic push_pair(input logic [15:0] x, input logic [15:0] y);
      bus_write(3'd2, {16'd0, x});
      bus_write(3'd3, {16'd0, y});
   endtask

   task automatic wait_until(input int c);
      int guard;
      guard = 0;
      while (cyc < c && guard < 2000) begin
         @(negedge clk_clk);
         guard++;
      end
      if (cyc < c) check("wait_timeout", 32'(cyc), 32'(c));
   endtask

   task automatic do_reset();
      reset_reset_n = 1'b0;
      avs_write = 1'b0; avs_read = 1'b0;
      @(posedge clk_clk);
      model_reset();
      @(negedge clk_clk);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_readdata"}, avs_readdata, 32'd0);
      check({tag, "_irq"}, {31'd0, irq}, 32'd0);
      for (int a = 0; a < 8; a++) bus_read(3'(a), $sformatf("%s_reg%0d", tag, a), 1'b1, 32'd0);
   endtask

   int ts;

   initial begin
      model_reset();
      @(negedge clk_clk);
      do_reset();
      mon_en = 1'b1;
      check_all_zero("reset");

      // Three mixed-sign pairs; done timing at T+7/T+8.
      push_pair(16'd3, 16'd4);
      push_pair(16'hFFFE, 16'd5);
      push_pair(16'd7, 16'hFFFF);
      bus_read(3'd1, "level3", 1'b1, 32'h0000_0300);
      ts = cyc;
      bus_write(3'd0, 32'h1);
      wait_until(ts + 7);
      bus_read(3'd1, "t1_busy_t7", 1'b1, 32'h0000_0001);
      bus_read(3'd1, "t1_done_t8", 1'b1, 32'h0000_0002);
      bus_read(3'd4, "t1_res_lo", 1'b1, 32'hFFFF_FFFB);
      bus_read(3'd5, "t1_res_hi", 1'b1, 32'hFFFF_FFFF);
      bus_read(3'd6, "t1_count", 1'b1, 32'd3);

      // Empty start: busy for 4 cycles, done at T+5, results untouched.
      ts = cyc;
      bus_write(3'd0, 32'h1);
      for (int i = 1; i <= 5; i++)
         bus_read(3'd1, $sformatf("empty_t%0d", i), 1'b1, (i == 5) ? 32'h2 : 32'h1);
      bus_read(3'd4, "empty_res_lo", 1'b1, 32'hFFFF_FFFB);
      bus_read(3'd6, "empty_count", 1'b1, 32'd3);

      // Largest positive products.
      bus_write(3'd0, 32'h2);
      for (int i = 0; i < 4; i++) push_pair(16'h7FFF, 16'h7FFF);
      bus_write(3'd0, 32'h1);
      wait_until(m_done_from);
      bus_read(3'd4, "max_res_lo", 1'b1, 32'hFFFC_0004);
      bus_read(3'd5, "max_res_hi", 1'b1, 32'h0000_0000);
      bus_read(3'd6, "max_count", 1'b1, 32'd4);

      // Seventeen pushes: last one dropped, overflow sticky.
      bus_write(3'd0, 32'h2);
      for (int i = 0; i < 17; i++) push_pair(16'(i * 301 - 2000), 16'(1234 - i * 977));
      bus_read(3'd1, "ovf_status", 1'b1, 32'h0000_1004);
      bus_write(3'd0, 32'h1);
      wait_until(m_done_from);
      bus_read(3'd6, "ovf_count", 1'b1, 32'd16);
      bus_read(3'd4, "ovf_res_lo", 1'b0, 32'd0);
      bus_read(3'd5, "ovf_res_hi", 1'b0, 32'd0);
      bus_read(3'd1, "ovf_status_done", 1'b1, 32'h0000_0006);

      // Clear in the middle of a run flushes FIFO and pipeline.
      bus_write(3'd0, 32'h2);
      for (int i = 0; i < 8; i++) push_pair(16'(100 * (i + 1)), 16'(-(i + 3)));
      ts = cyc;
      bus_write(3'd0, 32'h1);
      wait_until(ts + 3);
      bus_write(3'd0, 32'h2);
      bus_read(3'd1, "clr_status_next", 1'b1, 32'h0);
      wait_until(ts + 14);
      bus_read(3'd1, "clr_status", 1'b1, 32'h0);
      bus_read(3'd4, "clr_res_lo", 1'b1, 32'h0);
      bus_read(3'd5, "clr_res_hi", 1'b1, 32'h0);
      bus_read(3'd6, "clr_count", 1'b1, 32'h0);

      // Interrupt follows done; a new start drops it.
      bus_write(3'd0, 32'h4);
      push_pair(16'd5, 16'd6);
      ts = cyc;
      bus_write(3'd0, 32'h5);
      wait_until(ts + 5);
      check("irq_before_done", {31'd0, irq}, 32'd0);
      @(negedge clk_clk);
      check("irq_with_done", {31'd0, irq}, 32'd1);
      bus_write(3'd0, 32'h5);
      check("irq_dropped_by_start", {31'd0, irq}, 32'd0);
      wait_until(m_done_from);
      check("irq_second_done", {31'd0, irq}, 32'd1);
      bus_read(3'd4, "irq_res_lo", 1'b1, 32'd30);
      bus_write(3'd0, 32'h0);
      check("irq_en_off", {31'd0, irq}, 32'd0);

      // Reset mid-run returns everything, including the X latch, to zero.
      bus_write(3'd2, 32'h0000_0009);
      for (int i = 0; i < 4; i++) bus_write(3'd3, 32'(i + 2));
      ts = cyc;
      bus_write(3'd0, 32'h5);
      wait_until(ts + 2);
      do_reset();
      check_all_zero("midrst");
      bus_write(3'd3, 32'd7);
      bus_write(3'd0, 32'h1);
      wait_until(m_done_from);
      bus_read(3'd4, "xrst_res_lo", 1'b1, 32'd0);
      bus_read(3'd6, "xrst_count", 1'b1, 32'd1);

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
